// File: rtl/mips_pkg.sv
// Shared constants, state encoding and PC-select encoding for the fetch stage.
// The ERROR state exists only when PC_ALIGN_CHECK_EN is defined.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_ERROR  = 2'd3
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;
`endif

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'd0,
    SEL_INC   = 2'd1,
    SEL_REDIR = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux (hold / pc+4 / redirect target) with target alignment check.
// With PC_ALIGN_CHECK_EN the raw target is kept and misaligned_o flags bad low bits.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] redirect_target_i,
  input  pc_sel_t     sel_i,
`ifdef PC_ALIGN_CHECK_EN
  output logic        misaligned_o,
`endif
  output logic [31:0] pc_next_o
);

  logic [31:0] target_s;

`ifdef PC_ALIGN_CHECK_EN
  // A misaligned target never reaches the PC: the top level holds instead.
  assign target_s     = redirect_target_i;
  assign misaligned_o = (redirect_target_i[1:0] != 2'b00);
`else
  assign target_s = redirect_target_i & ~32'h0000_0003;
`endif

  // Select the next program counter value.
  always_comb begin
    pc_next_o = pc_i;
    case (sel_i)
      SEL_HOLD:  pc_next_o = pc_i;
      SEL_INC:   pc_next_o = pc_i + PC_INC;
      SEL_REDIR: pc_next_o = target_s;
      default:   pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID register, delivered-instruction counter and control FSM.
// Optional PC_ALIGN_CHECK_EN adds misalign_err and a sticky ERROR state for unaligned redirects.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  output logic [31:0] im_addr,
  input  logic [31:0] im_inst,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        halted,
`ifdef PC_ALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  output logic [31:0] fetch_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_inst_q, if_inst_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_pc_plus4_q, if_pc_plus4_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  pc_sel_t      pc_sel_s;
  logic [31:0]  pc_next_s;
`ifdef PC_ALIGN_CHECK_EN
  logic         misalign_q, misalign_d;
  logic         misaligned_s;
`endif

  pc_next_sel u_pc_next_sel (
    .pc_i              (pc_q),
    .redirect_target_i (redirect_target),
    .sel_i             (pc_sel_s),
`ifdef PC_ALIGN_CHECK_EN
    .misaligned_o      (misaligned_s),
`endif
    .pc_next_o         (pc_next_s)
  );

  // Next-state and datapath control; everything holds unless a branch below says otherwise.
  always_comb begin
    state_d       = state_q;
    pc_sel_s      = SEL_HOLD;
    if_valid_d    = if_valid_q;
    if_inst_d     = if_inst_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    fetch_count_d = fetch_count_q;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d    = misalign_q;
`endif
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redirect_valid) begin
`ifdef PC_ALIGN_CHECK_EN
          if (misaligned_s) begin
            state_d    = ST_ERROR;
            if_valid_d = 1'b0;
            misalign_d = 1'b1;
          end else begin
            pc_sel_s   = SEL_REDIR;
            if_valid_d = 1'b0;
          end
`else
          pc_sel_s   = SEL_REDIR;
          if_valid_d = 1'b0;
`endif
        end else if (stall) begin
          state_d = ST_RUN;
        end else if (halt) begin
          state_d    = ST_HALTED;
          if_valid_d = 1'b0;
        end else begin
          pc_sel_s      = SEL_INC;
          if_inst_d     = im_inst;
          if_pc_d       = pc_q;
          if_pc_plus4_d = pc_next_s;
          if_valid_d    = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
`ifdef PC_ALIGN_CHECK_EN
      ST_ERROR:  state_d = ST_ERROR;
`endif
      default:   state_d = ST_BOOT;
    endcase
  end

  assign pc_d = pc_next_s;

  // State, PC, IF/ID and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_inst_q     <= NOP_INST;
      if_pc_q       <= 32'h0000_0000;
      if_pc_plus4_q <= 32'h0000_0000;
      fetch_count_q <= 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_inst_q     <= if_inst_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      fetch_count_q <= fetch_count_d;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign im_addr     = pc_q;
  assign if_valid    = if_valid_q;
  assign if_inst     = if_inst_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_plus4_q;
  assign fetch_count = fetch_count_q;
  assign halted      = (state_q == ST_HALTED);
`ifdef PC_ALIGN_CHECK_EN
  assign misalign_err = misalign_q;
`endif

endmodule
